// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit for the EX stage: 32-cycle shift-add multiply and restoring divide.
// Optional feature: define MDU_FAST_MUL_EN for a single-cycle combinational multiply path.
module ex_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      ex_t,
    input  logic [2:0]      ex_st,
    input  logic            ex_m,
    input  logic [XLEN-1:0] ex_n1,
    input  logic [XLEN-1:0] ex_n2,
    input  logic [4:0]      ex_wa,
    input  logic            ex_we,
    output logic            stl,
    output logic [XLEN-1:0] mdu_res,
    output logic [4:0]      mdu_wa,
    output logic            mdu_we,
    output logic            mdu_vld
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        neg_q, neg_d;
    logic        negr_q, negr_d;
    logic        we_q, we_d;
    logic [4:0]  wa_q, wa_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  owa_q, owa_d;
    logic        owe_q, owe_d;
    logic        vld_q, vld_d;

    logic        start, n1_signed, n2_signed, neg1, neg2, div0, ovf;
    logic [31:0] mag1, mag2, special_res, quo, rem, iter_res;
    logic [32:0] mul_sum, trial;
    logic [63:0] mul_step, div_step, step, prod;

    assign start = (ex_t == 7'h33) && ex_m && (state_q == IDLE);
    assign stl   = rst && (start || state_q == BUSY);

    assign mdu_res = res_q;
    assign mdu_wa  = owa_q;
    assign mdu_we  = owe_q;
    assign mdu_vld = vld_q;

    always_comb begin
        n1_signed   = ex_st[2] ? ~ex_st[0] : (ex_st[1:0] != 2'd3);
        n2_signed   = ex_st[2] ? ~ex_st[0] : ~ex_st[1];
        neg1        = n1_signed && ex_n1[31];
        neg2        = n2_signed && ex_n2[31];
        mag1        = neg1 ? (32'd0 - ex_n1) : ex_n1;
        mag2        = neg2 ? (32'd0 - ex_n2) : ex_n2;
        div0        = ex_st[2] && (ex_n2 == 32'd0);
        ovf         = ex_st[2] && !ex_st[0] && (ex_n1 == 32'h8000_0000) && (ex_n2 == 32'hFFFF_FFFF);
        special_res = div0 ? (ex_st[1] ? ex_n1 : 32'hFFFF_FFFF)
                           : (ex_st[1] ? 32'd0 : 32'h8000_0000);

        // acc holds {product_hi, multiplier} for multiply and {remainder, dividend/quotient} for divide
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
        mul_step = {mul_sum, acc_q[31:1]};
        trial    = acc_q[63:31] - {1'b0, b_q};
        div_step = trial[32] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
        step     = op_q[2] ? div_step : mul_step;
        prod     = neg_q ? (64'd0 - step) : step;
        quo      = neg_q ? (32'd0 - step[31:0]) : step[31:0];
        rem      = negr_q ? (32'd0 - step[63:32]) : step[63:32];
        case (op_q)
            3'd0:          iter_res = prod[31:0];
            3'd1, 3'd2, 3'd3: iter_res = prod[63:32];
            3'd4, 3'd5:    iter_res = quo;
            default:       iter_res = rem;
        endcase
    end

`ifdef MDU_FAST_MUL_EN
    // In fast mode a multiply latches raw operands; neg_q/negr_q carry operand signedness instead
    logic signed [65:0] fast_prod;
    logic [31:0]        fast_res;
    always_comb begin
        fast_prod = $signed({neg_q && acc_q[31], acc_q[31:0]}) * $signed({negr_q && b_q[31], b_q});
        fast_res  = (op_q == 3'd0) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        op_d    = op_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        we_d    = we_q;
        wa_d    = wa_q;
        res_d   = res_q;
        owa_d   = owa_q;
        owe_d   = 1'b0;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d   = ex_st;
                    wa_d   = ex_wa;
                    we_d   = ex_we && (ex_wa != 5'd0);
                    cnt_d  = 5'd0;
                    acc_d  = {32'd0, mag1};
                    b_d    = mag2;
                    neg_d  = neg1 ^ neg2;
                    negr_d = neg1;
`ifdef MDU_FAST_MUL_EN
                    if (!ex_st[2]) begin
                        acc_d  = {32'd0, ex_n1};
                        b_d    = ex_n2;
                        neg_d  = n1_signed;
                        negr_d = n2_signed;
                    end
`endif
                    if (div0 || ovf) begin
                        state_d = DONE;
                        res_d   = special_res;
                        owa_d   = ex_wa;
                        owe_d   = ex_we && (ex_wa != 5'd0);
                        vld_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d = step;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                    res_d   = iter_res;
                    owa_d   = wa_q;
                    owe_d   = we_q;
                    vld_d   = 1'b1;
                end
`ifdef MDU_FAST_MUL_EN
                if (!op_q[2]) begin
                    state_d = DONE;
                    res_d   = fast_res;
                    owa_d   = wa_q;
                    owe_d   = we_q;
                    vld_d   = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            b_q     <= 32'd0;
            op_q    <= 3'd0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            we_q    <= 1'b0;
            wa_q    <= 5'd0;
            res_q   <= 32'd0;
            owa_q   <= 5'd0;
            owe_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            res_q   <= res_d;
            owa_q   <= owa_d;
            owe_q   <= owe_d;
            vld_q   <= vld_d;
        end
    end
endmodule

// File: tb/tb_ex_mdu.sv
// Randomized scoreboard bench for ex_mdu: arithmetic reference model, stall-length and result checks.
module tb_ex_mdu;
    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  ex_t;
    logic [2:0]  ex_st;
    logic        ex_m;
    logic [31:0] ex_n1, ex_n2;
    logic [4:0]  ex_wa;
    logic        ex_we;
    logic        stl;
    logic [31:0] mdu_res;
    logic [4:0]  mdu_wa;
    logic        mdu_we, mdu_vld;

    ex_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .ex_t(ex_t), .ex_st(ex_st), .ex_m(ex_m),
        .ex_n1(ex_n1), .ex_n2(ex_n2), .ex_wa(ex_wa), .ex_we(ex_we),
        .stl(stl), .mdu_res(mdu_res), .mdu_wa(mdu_wa), .mdu_we(mdu_we), .mdu_vld(mdu_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wa;
        logic        we;
        logic [2:0]  op;
    } exp_t;

    exp_t scb[$];
    int   checks = 0;
    int   passes = 0;
    int   vld_seen = 0;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbx, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = {{32{a[31]}}, a};
        sbx = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sbx; return p[31:0]; end
            3'd1: begin p = sa * sbx; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sbx; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sbx; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst && mdu_vld) begin
            exp_t e;
            vld_seen++;
            checks++;
            if (scb.size() == 0) begin
                $display("FAIL unexpected_vld: got res=%h wa=%0d we=%0d, required no result", mdu_res, mdu_wa, mdu_we);
            end else begin
                e = scb.pop_front();
                if (mdu_res === e.res && mdu_wa === e.wa && mdu_we === e.we) begin
                    passes++;
                    $display("txn op=%0d res=%h wa=%0d we=%0d ok", e.op, mdu_res, mdu_wa, mdu_we);
                end else begin
                    $display("FAIL result op=%0d: got res=%h wa=%0d we=%0d, required res=%h wa=%0d we=%0d",
                             e.op, mdu_res, mdu_wa, mdu_we, e.res, e.wa, e.we);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after DONE
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we);
        exp_t e;
        int   exp_stl, n;
        logic special;
        e.res = model(op, a, b);
        e.wa  = wa;
        e.we  = we && (wa != 0);
        e.op  = op;
        scb.push_back(e);
        special = op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        exp_stl = special ? 1 : 33;
`ifdef MDU_FAST_MUL_EN
        if (!op[2]) exp_stl = 2;
`endif
        ex_t = 7'h33; ex_m = 1'b1; ex_st = op; ex_n1 = a; ex_n2 = b; ex_wa = wa; ex_we = we;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stl || n > 100) break;
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n == exp_stl) passes++;
        else $display("FAIL stl_len op=%0d: got %0d cycles, required %0d", op, n, exp_stl);
        @(posedge clk); #1;
        ex_m = 1'b0; ex_t = 7'h00;
    endtask

    initial begin
        int vld_before;
        logic [2:0]  op;
        logic [31:0] a, b;
        rst = 1'b0;
        ex_t = 7'h33; ex_m = 1'b1; ex_st = 3'd0; ex_n1 = 32'd3; ex_n2 = 32'd4; ex_wa = 5'd1; ex_we = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stl === 1'b0 && mdu_vld === 1'b0 && mdu_res === 32'd0 && mdu_wa === 5'd0 && mdu_we === 1'b0)
            passes++;
        else
            $display("FAIL reset_state: got stl=%b vld=%b res=%h wa=%0d we=%b, required all 0",
                     stl, mdu_vld, mdu_res, mdu_wa, mdu_we);
        ex_m = 1'b0; ex_t = 7'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
        issue(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 1'b1);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 1'b1);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b1);
        issue(3'd5, 32'd5, 32'd0, 5'd11, 1'b1);
        issue(3'd6, 32'd5, 32'd0, 5'd12, 1'b1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1);
        issue(3'd4, 32'd100, 32'd7, 5'd0, 1'b1);
        issue(3'd7, 32'hFFFF_FFFF, 32'h8000_0000, 5'd14, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            issue(op, a, b, 5'($urandom), 1'($urandom));
        end

        // Abandon a divide with reset when the iteration counter reads 10
        ex_t = 7'h33; ex_m = 1'b1; ex_st = 3'd5; ex_n1 = 32'hDEAD_BEEF; ex_n2 = 32'd3; ex_wa = 5'd4; ex_we = 1'b1;
        repeat (11) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (stl === 1'b0 && mdu_vld === 1'b0 && mdu_res === 32'd0 && mdu_wa === 5'd0 && mdu_we === 1'b0)
            passes++;
        else
            $display("FAIL mid_busy_reset: got stl=%b vld=%b res=%h wa=%0d we=%b, required all 0",
                     stl, mdu_vld, mdu_res, mdu_wa, mdu_we);
        ex_m = 1'b0; ex_t = 7'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        vld_before = vld_seen;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (vld_seen == vld_before) passes++;
        else $display("FAIL no_vld_after_reset: got %0d pulses, required 0", vld_seen - vld_before);

        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd20, 1'b1);

        repeat (2) @(posedge clk);
        checks++;
        if (scb.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending, required 0", scb.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
# ex_mdu

Iterative multiply/divide unit for the RV32M instructions. It sits in the EX stage, directly downstream of the ID/EX pipeline register, in parallel with the single-cycle ALU. It consumes the decoded operation and operands that ID/EX presents. It holds ID/EX and all earlier stages through `stl` while it computes, then presents a one-cycle registered result towards EX/MEM.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `ex_t` input 7: opcode from ID/EX; 7'h33 is an OP-class instruction.
- `ex_st` input 3: funct3 from ID/EX, selecting the operation.
- `ex_m` input 1: funct7[0] from ID/EX; 1 marks an M-extension instruction.
- `ex_n1` input 32: rs1 operand.
- `ex_n2` input 32: rs2 operand.
- `ex_wa` input 5: destination register.
- `ex_we` input 1: destination write enable.
- `stl` output 1: stall request to ID/EX and earlier stages; combinational.
- `mdu_res` output 32: result.
- `mdu_wa` output 5: destination register of the result.
- `mdu_we` output 1: write enable of the result.
- `mdu_vld` output 1: result-valid pulse.

## Operation
- `start = (ex_t == 7'h33) && ex_m && state == IDLE`.
- `ex_st` encoding:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- States:
  - IDLE: waiting for `start`.
  - BUSY: 5-bit iteration counter running.
  - DONE: result presented for one cycle.
- IDLE→BUSY on `start`:
  - Latch operand magnitudes and result sign.
  - Latch `ex_wa`, and `ex_we && ex_wa != 0`.
  - Clear the counter.
- IDLE→DONE on `start` for special divide cases; no iteration is run:
  - Divide by zero: quotient = 32'hFFFFFFFF, remainder = `ex_n1`.
  - Signed overflow (DIV/REM with `ex_n1 = 32'h80000000`, `ex_n2 = 32'hFFFFFFFF`): quotient = 32'h80000000, remainder = 0.
- BUSY multiply:
  - Shift-add, one bit per cycle, into a 64-bit unsigned accumulator.
  - Signed forms operate on magnitudes; the product is negated at completion when the signs differ.
  - MULHSU treats `ex_n2` as unsigned.
- BUSY divide:
  - Restoring division, one quotient bit per cycle, on magnitudes.
  - Quotient sign = sign(n1) XOR sign(n2); remainder sign = sign(n1).
- BUSY→DONE when the counter equals 31 at the edge. The sign fix and result select (low/high product, quotient, remainder) are registered into `mdu_res` on that edge.
- DONE→IDLE unconditionally. While in DONE:
  - `mdu_vld` = 1.
  - `mdu_we` = latched write enable.
  - `mdu_res` and `mdu_wa` hold their values until the next DONE.
- `stl = start || state == BUSY`. It is low in DONE, so ID/EX loads the next instruction on the DONE edge, and the held M instruction is not re-accepted.
- Non-M instructions (`ex_m = 0`, or `ex_t != 7'h33`) are ignored in every state.

## Timing
- Reset (asynchronous assert): state IDLE, counter 0, all outputs 0. `stl` is 0 while reset is active.
- Reset asserted mid-BUSY abandons the operation; no `mdu_vld` is produced.
- Instruction first visible in cycle T:
  - `stl` is high in T..T+32 (33 cycles).
  - `mdu_vld` is high in T+33.
- Special divide cases: `stl` high in T only; `mdu_vld` in T+1.
- A back-to-back M instruction that arrives in the cycle after DONE is accepted normally from IDLE.
- ID/EX zeroing `ex_t` while `stl` is high does not affect an operation already in BUSY.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MUL* completes with a single BUSY cycle, using a combinational 33x33 signed product.
  - `stl` is high in T..T+1; `mdu_vld` in T+2.
  - Divide timing is unchanged.
- `MDU_FAST_MUL_EN` undefined: multiply is iterative, as in Operation; no multiplier array is inferred.

## Test plan
- MUL, n1=7, n2=-3, wa=5, we=1:
  - `stl` high 33 cycles.
  - Then `mdu_vld`=1, `mdu_res`=32'hFFFFFFEB, `mdu_wa`=5, `mdu_we`=1.
- MULH/MULHSU/MULHU with n1=32'h80000000, n2=32'hFFFFFFFF:
  - MULH → 0.
  - MULHSU → 32'h80000000.
  - MULHU → 32'h7FFFFFFF.
- DIV, n1=-7, n2=2 → 32'hFFFFFFFD. REM of the same operands → 32'hFFFFFFFF.
- Special divide cases:
  - DIVU 5/0 → 32'hFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 32'h80000000/-1 → 32'h80000000.
  - Each with `stl` high for exactly 1 cycle.
- DIV with wa=0, we=1 → `mdu_vld`=1, `mdu_we`=0.
- Reset pulse at BUSY counter 10 → all outputs 0, `stl`=0, and no `mdu_vld` afterwards.
- A following MULHU completes normally.
